multicycle_ctrl: RTL

//  Multi-cycle control FSM that sequences the rv32i datapath (PC, IR, memory, regfile, ALU).
//  Out of reset it optionally streams a program image into memory over a valid/ready boot port.
//  It then runs fetch/decode/execute, driving every datapath enable and mux select.

---
 rtl/multicycle_ctrl_if.sv | 11 +
 rtl/multicycle_ctrl.sv | 92 +++++++++
 2 files changed

// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: boot stream port and flash write bus of the multicycle controller.
interface multicycle_ctrl_if #(parameter int WIDTH = 32);
    logic             boot_valid;
    logic             boot_ready;
    logic [WIDTH-1:0] boot_data;
    logic             flash_en;
    logic [WIDTH-1:0] flash_addr;
    logic [WIDTH-1:0] flash_data;
    modport master (output boot_valid, boot_data, input boot_ready, flash_en, flash_addr, flash_data);
    modport slave  (input boot_valid, boot_data, output boot_ready, flash_en, flash_addr, flash_data);
endinterface

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: boot loader plus fetch/decode/execute sequencer for an rv32i datapath.
// Define CTRL_PERF_CNT_EN to add the cycle_cnt/instret_cnt performance counters.
module multicycle_ctrl #(
    parameter int WIDTH         = 32,
    parameter int BOOT_WORDS    = 256,
    parameter bit BOOT_ON_RESET = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [6:0]           opcode,
    input  logic                 run,
    multicycle_ctrl_if.slave     bus,
    output logic                 regfile_wren,
    output logic                 ir_wren,
    output logic                 pc_inc,
    output logic                 mem_wren,
    output logic                 ram_raddr_31_20,
    output logic [1:0]           regfile_load_from_alu_mem_pcp4,
    output logic                 halted
`ifdef CTRL_PERF_CNT_EN
    ,
    output logic [31:0]          cycle_cnt,
    output logic [31:0]          instret_cnt
`endif
);
    localparam int CW = $clog2(BOOT_WORDS) + 1;
    localparam logic [6:0] OP = 7'h33, OP_IMM = 7'h13, LOAD = 7'h03, STORE = 7'h23;
    localparam logic [1:0] SEL_ALU = 2'd0, SEL_MEM = 2'd1;
    typedef enum logic [3:0] {
        BOOT, IDLE, FETCH, FETCH_WAIT, DECODE, EXEC_ALU, LD_ADDR, LD_WB, ST, HALT
    } state_t;
    state_t          state, nxt;
    logic [CW-1:0]   boot_cnt;
    logic            accept;
    // boot_ready stays low during and just after reset, so no word is taken before BOOT is entered
    assign accept         = bus.boot_ready & bus.boot_valid;
    assign bus.flash_en   = accept;
    assign bus.flash_addr = accept ? WIDTH'({boot_cnt, 2'b00}) : '0;
    assign bus.flash_data = accept ? bus.boot_data : '0;
    always_comb begin
        nxt = IDLE;
        case (state)
            BOOT:       nxt = (accept && boot_cnt == CW'(BOOT_WORDS - 1)) ? IDLE : BOOT;
            IDLE:       nxt = run ? FETCH : IDLE;
            FETCH:      nxt = FETCH_WAIT;
            FETCH_WAIT: nxt = DECODE;
            DECODE:     nxt = (opcode == OP || opcode == OP_IMM) ? EXEC_ALU :
                              opcode == LOAD ? LD_ADDR : opcode == STORE ? ST : HALT;
            LD_ADDR:    nxt = LD_WB;
            EXEC_ALU, LD_WB, ST: nxt = run ? FETCH : IDLE;
            HALT:       nxt = HALT;
            default:    nxt = IDLE;
        endcase
    end
    // outputs are registered from the next state so they always match the state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state                          <= BOOT_ON_RESET ? BOOT : IDLE;
            boot_cnt                       <= '0;
            bus.boot_ready                 <= 1'b0;
            regfile_wren                   <= 1'b0;
            ir_wren                        <= 1'b0;
            pc_inc                         <= 1'b0;
            mem_wren                       <= 1'b0;
            ram_raddr_31_20                <= 1'b0;
            regfile_load_from_alu_mem_pcp4 <= SEL_ALU;
            halted                         <= 1'b0;
        end else begin
            state                          <= nxt;
            boot_cnt                       <= accept ? boot_cnt + 1'b1 : boot_cnt;
            bus.boot_ready                 <= nxt == BOOT;
            regfile_wren                   <= nxt == EXEC_ALU || nxt == LD_WB;
            ir_wren                        <= nxt == FETCH_WAIT;
            pc_inc                         <= nxt == EXEC_ALU || nxt == LD_WB || nxt == ST;
            mem_wren                       <= nxt == ST;
            ram_raddr_31_20                <= nxt == LD_ADDR || nxt == LD_WB || nxt == ST;
            regfile_load_from_alu_mem_pcp4 <= nxt == LD_WB ? SEL_MEM : SEL_ALU;
            halted                         <= nxt == HALT;
        end
    end
`ifdef CTRL_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            cycle_cnt   <= cycle_cnt + 32'(state != BOOT && state != HALT);
            instret_cnt <= instret_cnt + 32'(pc_inc);
        end
    end
`endif
endmodule
